spi_master_seq: RTL and testbench

- SPI initiator for the DCFEB front-end serial devices: comparator DAC, calibration DAC and calibration ADC.
- Accepts one transaction request at a time, drives SPI_CK, SPI_DAT and one active-high device enable, and captures SPI_RTN into a read word.
- Outputs connect directly to the pad-level SPI port wrapper, which inverts the enables into active-low chip selects.
- SPI mode 0, MSB first.

---
 rtl/spi_master_seq.sv | 206 ++++++++++++++++++++
 tb/tb_spi_master_seq.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_seq.sv
// ----------------------------------------------------------------------------
// spi_master_seq
//
// SPI initiator (mode 0, MSB first) for the DCFEB front-end serial devices:
// comparator DAC, calibration DAC and calibration ADC. It accepts one request
// at a time, drives SPI_CK, SPI_DAT and one active-high device enable, and
// shifts SPI_RTN into a right-aligned read word.
//
// Parameters:
//   CLK_DIV   half-period of SPI_CK in CLK cycles (1..255)
//   MAX_BITS  longest transaction; width of WR_DATA and RD_DATA
//
// Ports:
//   CLK, RST_B             system clock, asynchronous active-low reset
//   START                  request strobe, looked at only while idle
//   DEV_SEL                0=comp DAC, 1=cal DAC, 2=cal ADC, 3=illegal
//   NBITS                  transaction length (1..MAX_BITS)
//   WR_DATA                right-aligned write word, bit NBITS-1 goes first
//   BUSY                   transaction in progress
//   DONE                   one-cycle pulse, RD_DATA valid from this cycle
//   ERR                    one-cycle pulse on a rejected request
//   RD_DATA                captured return bits, right-aligned
//   SPI_CK, SPI_DAT        serial clock and data out, both idle low
//   SPI_RTN                serial data return
//   CDAC_ENB, CALDAC_ENB,
//   CALADC_ENB             active-high device enables
// ----------------------------------------------------------------------------
module spi_master_seq #(
    parameter int CLK_DIV  = 4,
    parameter int MAX_BITS = 32
) (
    input  logic                CLK,
    input  logic                RST_B,
    input  logic                START,
    input  logic [1:0]          DEV_SEL,
    input  logic [5:0]          NBITS,
    input  logic [MAX_BITS-1:0] WR_DATA,
    output logic                BUSY,
    output logic                DONE,
    output logic                ERR,
    output logic [MAX_BITS-1:0] RD_DATA,
    output logic                SPI_CK,
    output logic                SPI_DAT,
    input  logic                SPI_RTN,
    output logic                CDAC_ENB,
    output logic                CALDAC_ENB,
    output logic                CALADC_ENB
);

    typedef enum logic [2:0] {IDLE, SETUP, CK_HI, CK_LO, HOLD, GAP} state_t;

    localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);

    state_t              state, state_n;
    logic [7:0]          div, div_n;
    logic [5:0]          cnt, cnt_n;
    logic [MAX_BITS-1:0] tx, tx_n;
    logic [MAX_BITS-1:0] rx, rx_n;
    logic [MAX_BITS-1:0] rd_n;
    logic [2:0]          en, en_n;
    logic                busy_n, done_n, err_n, ck_n, dat_n;
    logic                req_ok;
    logic [6:0]          shamt;
    logic [MAX_BITS-1:0] aligned;

    assign req_ok  = (DEV_SEL != 2'd3) && (NBITS != 6'd0) && (int'(NBITS) <= MAX_BITS);

    // Left-justify the write word so the first bit to send is always the MSB;
    // only meaningful when the request is legal.
    assign shamt   = 7'(MAX_BITS) - 7'(NBITS);
    assign aligned = WR_DATA << shamt;

    assign CDAC_ENB   = en[0];
    assign CALDAC_ENB = en[1];
    assign CALADC_ENB = en[2];

    // State and every output are registered together, so nothing combinational
    // reaches a port; the comb block below computes all next values.
    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            state   <= IDLE;
            div     <= '0;
            cnt     <= '0;
            tx      <= '0;
            rx      <= '0;
            en      <= '0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            ERR     <= 1'b0;
            RD_DATA <= '0;
            SPI_CK  <= 1'b0;
            SPI_DAT <= 1'b0;
        end else begin
            state   <= state_n;
            div     <= div_n;
            cnt     <= cnt_n;
            tx      <= tx_n;
            rx      <= rx_n;
            en      <= en_n;
            BUSY    <= busy_n;
            DONE    <= done_n;
            ERR     <= err_n;
            RD_DATA <= rd_n;
            SPI_CK  <= ck_n;
            SPI_DAT <= dat_n;
        end
    end

    // Every timed state runs the divider from DIV_LOAD down to zero, giving
    // exactly CLK_DIV cycles per phase. cnt holds the bits still to clock out.
    always_comb begin
        state_n = state;
        div_n   = div;
        cnt_n   = cnt;
        tx_n    = tx;
        rx_n    = rx;
        en_n    = en;
        busy_n  = BUSY;
        done_n  = 1'b0;
        err_n   = 1'b0;
        rd_n    = RD_DATA;
        ck_n    = SPI_CK;
        dat_n   = SPI_DAT;
        case (state)
            IDLE: begin
                if (START) begin
                    if (req_ok) begin
                        state_n = SETUP;
                        div_n   = DIV_LOAD;
                        cnt_n   = NBITS;
                        tx_n    = aligned << 1;
                        rx_n    = '0;
                        en_n    = 3'b001 << DEV_SEL;
                        busy_n  = 1'b1;
                        ck_n    = 1'b0;
                        dat_n   = aligned[MAX_BITS-1];
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            SETUP: begin
                if (div == 8'd0) begin
                    state_n = CK_HI;
                    ck_n    = 1'b1;
                    div_n   = DIV_LOAD;
                end else begin
                    div_n = div - 8'd1;
                end
            end
            CK_HI: begin
                // The return bit is taken in the first cycle of the high phase.
                if (div == DIV_LOAD) begin
                    rx_n = {rx[MAX_BITS-2:0], SPI_RTN};
                end
                if (div == 8'd0) begin
                    ck_n  = 1'b0;
                    div_n = DIV_LOAD;
                    if (cnt == 6'd1) begin
                        state_n = HOLD;
                        dat_n   = 1'b0;
                    end else begin
                        state_n = CK_LO;
                        cnt_n   = cnt - 6'd1;
                        dat_n   = tx[MAX_BITS-1];
                        tx_n    = tx << 1;
                    end
                end else begin
                    div_n = div - 8'd1;
                end
            end
            CK_LO: begin
                if (div == 8'd0) begin
                    state_n = CK_HI;
                    ck_n    = 1'b1;
                    div_n   = DIV_LOAD;
                end else begin
                    div_n = div - 8'd1;
                end
            end
            HOLD: begin
                if (div == 8'd0) begin
                    state_n = GAP;
                    en_n    = 3'b000;
                    done_n  = 1'b1;
                    rd_n    = rx;
                    div_n   = DIV_LOAD;
                end else begin
                    div_n = div - 8'd1;
                end
            end
            GAP: begin
                if (div == 8'd0) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                end else begin
                    div_n = div - 8'd1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_master_seq.sv
// ----------------------------------------------------------------------------
// tb_spi_master_seq
//
// Directed bench for spi_master_seq. Instance "a" runs with CLK_DIV=4, and
// instance "b" with CLK_DIV=1 covers the shortest timing. Expected read words
// are queued when a request is issued and popped when DONE appears.
// ----------------------------------------------------------------------------
module tb_spi_master_seq;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        start_a, busy_a, done_a, err_a;
    logic [1:0]  dev_a;
    logic [5:0]  nbits_a;
    logic [31:0] wr_a, rd_a;
    logic        ck_a, dat_a, rtn_a, cdac_a, caldac_a, caladc_a;
    logic        loop_a, rtn_val_a;

    logic        start_b, busy_b, done_b, err_b;
    logic [1:0]  dev_b;
    logic [5:0]  nbits_b;
    logic [31:0] wr_b, rd_b;
    logic        ck_b, dat_b, rtn_b, cdac_b, caldac_b, caladc_b;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          t0 = 0;

    logic [31:0] sb[$];
    int          rise_t[$];
    logic        rise_d[$];
    int          done_t, done_cnt, busy_low_t, en_first, en_last, bad_en;
    logic [2:0]  en_mask;

    // Loopback feeds the registered SPI_DAT back, so there is no comb loop.
    assign rtn_a = loop_a ? dat_a : rtn_val_a;

    spi_master_seq #(.CLK_DIV(4), .MAX_BITS(32)) dut_a (
        .CLK(clk), .RST_B(rst_n), .START(start_a), .DEV_SEL(dev_a), .NBITS(nbits_a),
        .WR_DATA(wr_a), .BUSY(busy_a), .DONE(done_a), .ERR(err_a), .RD_DATA(rd_a),
        .SPI_CK(ck_a), .SPI_DAT(dat_a), .SPI_RTN(rtn_a),
        .CDAC_ENB(cdac_a), .CALDAC_ENB(caldac_a), .CALADC_ENB(caladc_a)
    );

    spi_master_seq #(.CLK_DIV(1), .MAX_BITS(32)) dut_b (
        .CLK(clk), .RST_B(rst_n), .START(start_b), .DEV_SEL(dev_b), .NBITS(nbits_b),
        .WR_DATA(wr_b), .BUSY(busy_b), .DONE(done_b), .ERR(err_b), .RD_DATA(rd_b),
        .SPI_CK(ck_b), .SPI_DAT(dat_b), .SPI_RTN(rtn_b),
        .CDAC_ENB(cdac_b), .CALDAC_ENB(caldac_b), .CALADC_ENB(caladc_b)
    );

    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive a request on instance a in the current cycle (t0) and clear the
    // per-transaction records.
    task automatic apply_stimulus(input logic [1:0] dev, input logic [5:0] nbits,
                                  input logic [31:0] wr, input bit push,
                                  input logic [31:0] exp_rd);
        dev_a   = dev;
        nbits_a = nbits;
        wr_a    = wr;
        start_a = 1'b1;
        t0      = cyc;
        if (push) sb.push_back(exp_rd);
        rise_t.delete();
        rise_d.delete();
        done_t     = -1;
        done_cnt   = 0;
        busy_low_t = -1;
        en_first   = -1;
        en_last    = -1;
        bad_en     = 0;
        en_mask    = 3'b000;
    endtask

    // Follow instance a cycle by cycle until BUSY drops after DONE or the
    // budget runs out. pulse_at>0 raises START (with junk inputs) for one cycle.
    task automatic watch_a(input int budget, input int pulse_at);
        logic       prev_ck;
        logic [2:0] ens;
        int         rel;
        bit         finished;
        prev_ck  = ck_a;
        finished = 0;
        while (!finished && (cyc - t0) < budget) begin
            tick();
            rel = cyc - t0;
            if (ck_a && !prev_ck) begin
                rise_t.push_back(rel);
                rise_d.push_back(dat_a);
            end
            prev_ck = ck_a;
            ens = {caladc_a, caldac_a, cdac_a};
            if (ens != 3'b000) begin
                if (en_first < 0) en_first = rel;
                en_last = rel;
            end
            en_mask |= ens;
            if ($countones(ens) > 1 || (ens != 3'b000 && !busy_a)) bad_en++;
            if (done_a) begin
                done_t = rel;
                done_cnt++;
                if (sb.size() > 0) check_output("rd_data", rd_a, sb.pop_front());
            end
            start_a = (rel == pulse_at);
            if (rel == pulse_at) begin
                wr_a    = 32'hFFFF_FFFF;
                nbits_a = 6'd3;
                dev_a   = 2'd0;
            end
            if (!busy_a && done_t >= 0) begin
                busy_low_t = rel;
                finished   = 1;
            end
        end
        start_a = 1'b0;
    endtask

    initial begin
        logic [7:0]  pat;
        logic [31:0] keep_rd;
        int          n_rise, b_rise_t, b_done_t;
        logic [31:0] b_rd;
        logic        prev_ck;

        rst_n = 1'b0;
        start_a = 1'b0; dev_a = '0; nbits_a = '0; wr_a = '0; loop_a = 1'b0; rtn_val_a = 1'b0;
        start_b = 1'b0; dev_b = '0; nbits_b = '0; wr_b = '0; rtn_b = 1'b0;
        tick();
        tick();
        check_output("reset_busy", busy_a, 1'b0);
        check_output("reset_outs", {ck_a, dat_a, cdac_a, caldac_a, caladc_a, done_a, err_a}, 7'd0);
        check_output("reset_rd", rd_a, 32'h0);
        rst_n = 1'b1;
        tick();

        // Write 0xA5 to the comparator DAC.
        $display("[TB] write 8 bits, CLK_DIV=4");
        apply_stimulus(2'd0, 6'd8, 32'h0000_00A5, 1, 32'h0);
        watch_a(200, -1);
        pat = 8'hA5;
        check_output("wr_rise_count", rise_t.size(), 8);
        for (int k = 0; k < 8; k++) begin
            check_output("wr_rise_time", (k < rise_t.size()) ? rise_t[k] : -1, 5 + 8 * k);
            check_output("wr_rise_data", (k < rise_d.size()) ? rise_d[k] : 1'bx, pat[7 - k]);
        end
        check_output("wr_en_first", en_first, 1);
        check_output("wr_en_last", en_last, 68);
        check_output("wr_en_mask", en_mask, 3'b001);
        check_output("wr_done_time", done_t, 69);
        check_output("wr_busy_low", busy_low_t, 73);
        check_output("wr_bad_en", bad_en, 0);

        // 32-bit loopback on the calibration ADC.
        $display("[TB] loopback 32 bits");
        loop_a = 1'b1;
        apply_stimulus(2'd2, 6'd32, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF);
        watch_a(400, -1);
        check_output("lb_rise_count", rise_t.size(), 32);
        check_output("lb_done_time", done_t, 261);
        check_output("lb_busy_low", busy_low_t, 265);
        check_output("lb_en_mask", en_mask, 3'b100);
        check_output("lb_bad_en", bad_en, 0);

        // Illegal requests are rejected with a single ERR pulse.
        $display("[TB] illegal requests");
        keep_rd = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            if (i == 0) apply_stimulus(2'd3, 6'd8, 32'h1, 0, 32'h0);
            else if (i == 1) apply_stimulus(2'd0, 6'd0, 32'h1, 0, 32'h0);
            else apply_stimulus(2'd1, 6'd33, 32'h1, 0, 32'h0);
            tick();
            start_a = 1'b0;
            check_output("ill_err", err_a, 1'b1);
            check_output("ill_quiet", {busy_a, ck_a, cdac_a, caldac_a, caladc_a}, 5'd0);
            check_output("ill_rd", rd_a, keep_rd);
            tick();
            check_output("ill_err_pulse", err_a, 1'b0);
            check_output("ill_busy_after", busy_a, 1'b0);
        end

        // START during a 16-bit transfer is ignored; a START on the first idle
        // cycle is accepted.
        $display("[TB] start while busy");
        apply_stimulus(2'd0, 6'd16, 32'h0000_1234, 1, 32'h0000_1234);
        watch_a(400, 20);
        check_output("bz_done_count", done_cnt, 1);
        check_output("bz_done_time", done_t, 133);
        check_output("bz_busy_low", busy_low_t, 137);
        apply_stimulus(2'd1, 6'd4, 32'h0000_0009, 1, 32'h0000_0009);
        tick();
        start_a = 1'b0;
        check_output("bz_accept_busy", busy_a, 1'b1);
        check_output("bz_accept_en", {caladc_a, caldac_a, cdac_a}, 3'b010);
        watch_a(200, -1);
        check_output("bz_next_done", done_t, 37);
        check_output("bz_next_busy_low", busy_low_t, 41);

        // Reset after the third rising edge of a 16-bit transfer.
        $display("[TB] reset mid-transfer");
        apply_stimulus(2'd2, 6'd16, 32'h0000_FFFF, 0, 32'h0);
        n_rise  = 0;
        prev_ck = ck_a;
        for (int c = 0; c < 100 && n_rise < 3; c++) begin
            tick();
            start_a = 1'b0;
            if (ck_a && !prev_ck) n_rise++;
            prev_ck = ck_a;
        end
        check_output("rst_rises_seen", n_rise, 3);
        rst_n = 1'b0;
        #1;
        check_output("rst_outs", {busy_a, ck_a, cdac_a, caldac_a, caladc_a, done_a}, 6'd0);
        check_output("rst_rd", rd_a, 32'h0);
        tick();
        rst_n = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 150; c++) begin
            tick();
            if (done_a) done_cnt++;
        end
        check_output("rst_no_done", done_cnt, 0);
        apply_stimulus(2'd0, 6'd8, 32'h0000_005A, 1, 32'h0000_005A);
        watch_a(200, -1);
        check_output("rst_next_done", done_t, 69);
        check_output("rst_next_busy_low", busy_low_t, 73);

        // Shortest timing: one-bit read with CLK_DIV=1.
        $display("[TB] one-bit read, CLK_DIV=1");
        dev_b = 2'd1; nbits_b = 6'd1; wr_b = 32'h0; rtn_b = 1'b1; start_b = 1'b1;
        t0 = cyc;
        n_rise = 0; b_rise_t = -1; b_done_t = -1; b_rd = 32'hx;
        prev_ck = ck_b;
        for (int c = 0; c < 10; c++) begin
            tick();
            start_b = 1'b0;
            if (cyc - t0 == 1) check_output("b_en", {caladc_b, caldac_b, cdac_b}, 3'b010);
            if (ck_b && !prev_ck) begin
                n_rise++;
                if (b_rise_t < 0) b_rise_t = cyc - t0;
            end
            prev_ck = ck_b;
            if (done_b && b_done_t < 0) begin
                b_done_t = cyc - t0;
                b_rd = rd_b;
            end
        end
        check_output("b_rise_count", n_rise, 1);
        check_output("b_rise_time", b_rise_t, 2);
        check_output("b_done_time", b_done_t, 4);
        check_output("b_rd", b_rd, 32'h0000_0001);
        check_output("b_idle", busy_b, 1'b0);

        check_output("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
